// File: rtl/text_lcd_ctrl.sv
// HD44780-style character LCD controller: power-up init sequence, then full
// screen frames (one set-address write per row followed by that row's chars),
// either refreshed continuously or on request with a one-deep pending flag.
module text_lcd_ctrl #(
  parameter int COLS        = 16,
  parameter int ROWS        = 2,
  parameter int INIT_DELAY  = 70,
  parameter int CMD_WAIT    = 30,
  parameter int CLR_WAIT    = 60,
  parameter int CHAR_WAIT   = 2,
  parameter int REFRESH_GAP = 100
) (
  input  logic                   CLK,
  input  logic                   RESETN,      // active-high despite the name
  input  logic [8*COLS*ROWS-1:0] TEXT,
  input  logic                   AUTO,
  input  logic                   UPDATE_REQ,
  output logic                   BUSY,
  output logic                   INIT_DONE,
  output logic                   FRAME_DONE,
  output logic                   LCD_E,
  output logic                   LCD_RS,
  output logic                   LCD_RW,
  output logic [7:0]             LCD_DATA
);

  // One counter serves every delay, so it is sized for the longest one.
  // INIT_DELAY and REFRESH_GAP are assumed >= 1; the post-write waits may be 0.
  localparam int W01   = (INIT_DELAY > CMD_WAIT)  ? INIT_DELAY : CMD_WAIT;
  localparam int W23   = (CLR_WAIT   > CHAR_WAIT) ? CLR_WAIT   : CHAR_WAIT;
  localparam int W03   = (W01 > W23) ? W01 : W23;
  localparam int MAXW  = (W03 > REFRESH_GAP) ? W03 : REFRESH_GAP;
  localparam int CW    = $clog2(MAXW + 1);
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CLW   = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [CW-1:0]  INIT_M1  = CW'(INIT_DELAY - 1);
  localparam logic [CW-1:0]  GAP_M1   = CW'(REFRESH_GAP - 1);
  localparam logic [CLW-1:0] LAST_COL = CLW'(COLS - 1);
  localparam logic [RW-1:0]  LAST_ROW = RW'(ROWS - 1);
  localparam logic [7:0]     COLS8    = 8'(COLS);

  typedef enum logic [3:0] {
    S_PWR, S_FSET, S_DON, S_EMS, S_CLR, S_IDLE, S_ADDR, S_CHAR, S_GAP
  } state_t;

  // Every bus write runs W1 (E high) -> W2 (E low) -> WT (post-write wait).
  typedef enum logic [1:0] {P_W1, P_W2, P_WT} ph_t;

  state_t                              r_state, w_nxt;
  ph_t                                 r_ph;
  logic [CW-1:0]                       r_cnt;
  logic [RW-1:0]                       r_row;
  logic [CLW-1:0]                      r_col;
  logic                                r_pend, r_init, r_fdone;
  logic [ROWS-1:0][COLS-1:0][7:0]      r_buf;
  logic                                w_isw, w_wdone, w_cap, w_last_col, w_last_row;
  logic [CW-1:0]                       w_wait;
  logic [7:0]                          w_base;

  assign w_isw      = (r_state == S_FSET) || (r_state == S_DON) || (r_state == S_EMS) ||
                      (r_state == S_CLR)  || (r_state == S_ADDR) || (r_state == S_CHAR);
  assign w_last_col = (r_col == LAST_COL);
  assign w_last_row = (r_row == LAST_ROW);
  // The first cycle of a frame is row 0's address W1; the text is frozen here.
  assign w_cap      = (r_state == S_ADDR) && (r_row == '0) && (r_ph == P_W1);
  assign INIT_DONE  = r_init;
  assign FRAME_DONE = r_fdone;

  // Post-write wait length for the current write and its completion strobe.
  always_comb begin
    w_wait  = '0;
    w_wdone = 1'b0;
    case (r_state)
      S_FSET, S_DON, S_EMS: w_wait = CW'(CMD_WAIT);
      S_CLR:                w_wait = CW'(CLR_WAIT);
      S_ADDR, S_CHAR:       w_wait = CW'(CHAR_WAIT);
      default:              w_wait = '0;
    endcase
    if (w_isw) begin
      if (r_ph == P_W2 && w_wait == '0)                    w_wdone = 1'b1;
      else if (r_ph == P_WT && r_cnt == w_wait - 1'b1)     w_wdone = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge RESETN) begin
    if (RESETN) r_state <= S_PWR;
    else        r_state <= w_nxt;
  end

  // Next-state logic; AUTO/pending only matter at init end, frame end, IDLE and GAP.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_PWR:  if (r_cnt == INIT_M1) w_nxt = S_FSET;
      S_FSET: if (w_wdone) w_nxt = S_DON;
      S_DON:  if (w_wdone) w_nxt = S_EMS;
      S_EMS:  if (w_wdone) w_nxt = S_CLR;
      S_CLR:  if (w_wdone) w_nxt = (AUTO || r_pend) ? S_ADDR : S_IDLE;
      S_IDLE: if (UPDATE_REQ || AUTO || r_pend) w_nxt = S_ADDR;
      S_ADDR: if (w_wdone) w_nxt = S_CHAR;
      S_CHAR: if (w_wdone && w_last_col)
                w_nxt = !w_last_row ? S_ADDR : (AUTO ? S_GAP : S_IDLE);
      S_GAP:  if (r_cnt == GAP_M1) w_nxt = (AUTO || r_pend) ? S_ADDR : S_IDLE;
      default: w_nxt = S_PWR;
    endcase
  end

  // Write phase, delay counter, row/column cursor and status flags.
  always_ff @(posedge CLK or posedge RESETN) begin
    if (RESETN) begin
      r_ph    <= P_W1;
      r_cnt   <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_pend  <= 1'b0;
      r_init  <= 1'b0;
      r_fdone <= 1'b0;
    end else begin
      r_fdone <= (r_state == S_CHAR) && w_wdone && w_last_col && w_last_row;
      if (r_state == S_CLR && w_wdone) r_init <= 1'b1;
      // A request during a capture cycle wins: that frame may already be stale.
      if (UPDATE_REQ && BUSY) r_pend <= 1'b1;
      else if (w_cap)         r_pend <= 1'b0;
      if (w_nxt != r_state || w_wdone) begin
        r_ph  <= P_W1;
        r_cnt <= '0;
      end else if (w_isw) begin
        case (r_ph)
          P_W1:    r_ph <= P_W2;
          P_W2:    begin r_ph <= P_WT; r_cnt <= '0; end
          default: r_cnt <= r_cnt + 1'b1;
        endcase
      end else if (r_state == S_PWR || r_state == S_GAP) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == S_CHAR && w_wdone) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end else if (r_state != S_ADDR && r_state != S_CHAR) begin
        r_row <= '0;
        r_col <= '0;
      end
    end
  end

  // Frame text snapshot, so TEXT changes mid-frame only show in the next frame.
  always_ff @(posedge CLK or posedge RESETN) begin
    if (RESETN)     r_buf <= '0;
    else if (w_cap) r_buf <= TEXT;
  end

  // Bus and status outputs decoded from state; RS/DATA hold for a whole write + wait.
  always_comb begin
    LCD_E    = w_isw && (r_ph == P_W1);
    LCD_RS   = (r_state == S_CHAR);
    LCD_RW   = 1'b0;
    BUSY     = (r_state != S_IDLE) || r_pend;
    case (int'(r_row))
      1:       w_base = 8'h40;
      2:       w_base = COLS8;
      3:       w_base = 8'h40 + COLS8;
      default: w_base = 8'h00;
    endcase
    case (r_state)
      S_FSET:  LCD_DATA = 8'h38;
      S_DON:   LCD_DATA = 8'h0C;
      S_EMS:   LCD_DATA = 8'h06;
      S_CLR:   LCD_DATA = 8'h01;
      S_ADDR:  LCD_DATA = 8'h80 | w_base;
      S_CHAR:  LCD_DATA = r_buf[r_row][r_col];
      default: LCD_DATA = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_text_lcd_ctrl.sv
// Bench for text_lcd_ctrl: a default 16x2 instance for init, request, pending,
// AUTO and mid-frame reset; a 4x20 instance for row addressing and frame length.
module tb_text_lcd_ctrl;
  localparam int C = 16, R = 2, C4 = 20, R4 = 4;

  typedef struct {logic rs; logic [7:0] d; int t;} wr_t;
  typedef struct {string tag; logic rs; logic [7:0] d;} vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1, aut = 1'b0, req = 1'b0;
  logic [8*C*R-1:0] text = '0;
  logic busy, idone, fdone, e, rs, rw;
  logic [7:0] d;
  logic rst4 = 1'b1, aut4 = 1'b0, req4 = 1'b0;
  logic [8*C4*R4-1:0] text4 = '0;
  logic busy4, idone4, fdone4, e4, rs4, rw4;
  logic [7:0] d4;

  int nchk = 0, nerr = 0;
  int ecnt = 0, ecnt4 = 0, viol = 0, blow = 0, itime = -1;
  wr_t wq[$], wq4[$];
  int fq[$], fq4[$];
  wr_t wa, wb;
  logic pe = 1'b0, prs = 1'b0, pe4 = 1'b0, prs4 = 1'b0;
  logic [7:0] pd = '0, pd4 = '0;

  text_lcd_ctrl dut (
    .CLK(clk), .RESETN(rst), .TEXT(text), .AUTO(aut), .UPDATE_REQ(req),
    .BUSY(busy), .INIT_DONE(idone), .FRAME_DONE(fdone),
    .LCD_E(e), .LCD_RS(rs), .LCD_RW(rw), .LCD_DATA(d));

  text_lcd_ctrl #(.COLS(C4), .ROWS(R4)) dut4 (
    .CLK(clk), .RESETN(rst4), .TEXT(text4), .AUTO(aut4), .UPDATE_REQ(req4),
    .BUSY(busy4), .INIT_DONE(idone4), .FRAME_DONE(fdone4),
    .LCD_E(e4), .LCD_RS(rs4), .LCD_RW(rw4), .LCD_DATA(d4));

  always #5 clk = ~clk;

  // rising edges since reset release
  always @(posedge clk) ecnt  <= rst  ? 0 : ecnt + 1;
  always @(posedge clk) ecnt4 <= rst4 ? 0 : ecnt4 + 1;

  // bus monitors: log writes and FRAME_DONE pulses, flag W2/RW protocol breaks
  always @(negedge clk) begin
    if (!rst) begin
      if (e) begin wa.rs = rs; wa.d = d; wa.t = ecnt; wq.push_back(wa); end
      if (fdone) fq.push_back(ecnt);
      if (!busy) blow++;
      if (idone && itime < 0) itime = ecnt;
      if (rw || (pe && (e || rs != prs || d != pd))) viol++;
    end
    pe = e && !rst; prs = rs; pd = d;
  end

  always @(negedge clk) begin
    if (!rst4) begin
      if (e4) begin wb.rs = rs4; wb.d = d4; wb.t = ecnt4; wq4.push_back(wb); end
      if (fdone4) fq4.push_back(ecnt4);
      if (rw4 || (pe4 && (e4 || rs4 != prs4 || d4 != pd4))) viol++;
    end
    pe4 = e4 && !rst4; prs4 = rs4; pd4 = d4;
  end

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_wr(input int n, input int lim);
    int k = 0;
    while (wq.size() < n && k < lim) begin @(negedge clk); #1; k++; end
    chk("write_timeout", int'(wq.size() >= n), 1);
  endtask

  task automatic wait_fd(input int n, input int lim);
    int k = 0;
    while (fq.size() < n && k < lim) begin @(negedge clk); #1; k++; end
    chk("frame_done_timeout", int'(fq.size() >= n), 1);
  endtask

  task automatic wait_to(input int t);
    int k = 0;
    while (ecnt < t && k < 5000) begin @(posedge clk); #1; k++; end
  endtask

  // one-cycle request; f returns the edge count of the first frame cycle
  task automatic pulse_req(output int f);
    @(posedge clk); #1 req = 1'b1; f = ecnt + 1;
    @(posedge clk); #1 req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t hello[34];
    logic [7:0] init_d[4];
    logic [7:0] raddr[4];
    int b, f, n, b0, k;

    // expected writes for a "HELLO" frame on 16x2
    for (int i = 0; i < 34; i++) hello[i] = '{"space", 1'b1, 8'h20};
    hello[0]  = '{"addr_row0", 1'b0, 8'h80};
    hello[1]  = '{"char_H", 1'b1, 8'h48};
    hello[2]  = '{"char_E", 1'b1, 8'h45};
    hello[3]  = '{"char_L", 1'b1, 8'h4C};
    hello[4]  = '{"char_L", 1'b1, 8'h4C};
    hello[5]  = '{"char_O", 1'b1, 8'h4F};
    hello[17] = '{"addr_row1", 1'b0, 8'hC0};
    init_d = '{8'h38, 8'h0C, 8'h06, 8'h01};
    raddr  = '{8'h80, 8'hC0, 8'h94, 8'hD4};

    text = {C*R{8'h20}};
    text[39:0] = {8'h4F, 8'h4C, 8'h4C, 8'h45, 8'h48};

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_E", e, 0);        chk("rst_RS", rs, 0);     chk("rst_RW", rw, 0);
    chk("rst_DATA", d, 0);     chk("rst_BUSY", busy, 1); chk("rst_INIT_DONE", idone, 0);
    chk("rst_FRAME_DONE", fdone, 0);
    rst = 1'b0;

    // init sequence: 0x38 at edge 70, then every 2+CMD_WAIT=32 cycles
    wait_wr(4, 400);
    for (int i = 0; i < 4; i++) begin
      chk("init_data", wq[i].d, init_d[i]);
      chk("init_rs", wq[i].rs, 0);
      chk("init_time", wq[i].t, 70 + 32*i);
    end
    k = 0;
    while (!idone && k < 300) begin @(negedge clk); #1; k++; end
    // CLR W1 at 166, W2 167, 60 wait cycles -> INIT_DONE at 228
    chk("init_done_time", itime, 228);
    repeat (20) @(negedge clk);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_no_writes", wq.size(), 4);
    chk("idle_E", e, 0);

    // on-demand HELLO frame
    b = wq.size(); n = fq.size();
    pulse_req(f);
    wait_fd(n + 1, 400);
    chk("hello_frame_done", fq[n], f + 136);
    chk("hello_write_count", wq.size() - b, 34);
    chk("hello_first_write_time", wq[b].t, f);
    for (int i = 0; i < 34; i++)
      if (b + i < wq.size()) begin
        chk({"hello_", hello[i].tag}, wq[b+i].d, hello[i].d);
        chk({"hello_rs_", hello[i].tag}, wq[b+i].rs, hello[i].rs);
      end
    repeat (3) @(negedge clk);
    #1;
    chk("hello_busy_after", busy, 0);

    // three requests inside one frame merge into exactly one extra frame
    b = wq.size(); n = fq.size();
    pulse_req(f);
    b0 = blow;
    wait_to(f + 20); pulse_req(k);
    wait_to(f + 45); pulse_req(k);
    wait_to(f + 90); pulse_req(k);
    wait_fd(n + 2, 600);
    chk("pend_frame1_done", fq[n], f + 136);
    chk("pend_frame2_done", fq[n+1], f + 137 + 136);
    // the only BUSY-low cycle is the closing FRAME_DONE cycle (in IDLE)
    chk("pend_busy_low_cycles", blow - b0, 1);
    repeat (300) @(negedge clk);
    #1;
    chk("pend_no_third_frame", fq.size(), n + 2);
    chk("pend_write_count", wq.size() - b, 68);

    // AUTO refresh: 136-cycle frames separated by a 100-cycle gap
    b = wq.size(); n = fq.size();
    @(posedge clk); #1 aut = 1'b1; f = ecnt + 1;
    wait_to(f + 50);
    text[8*31 +: 8] = 8'h5A;        // row 1, last column, after capture
    wait_fd(n + 2, 800);
    aut = 1'b0;
    chk("auto_frame1_done", fq[n], f + 136);
    chk("auto_frame2_done", fq[n+1], f + 236 + 136);
    chk("auto_frame2_start", wq[b+34].t, f + 236);
    chk("auto_old_text", wq[b+33].d, 8'h20);
    chk("auto_new_text", wq[b+67].d, 8'h5A);
    repeat (400) @(negedge clk);
    #1;
    chk("auto_stop_frames", fq.size(), n + 2);
    chk("auto_stop_busy", busy, 0);

    // asynchronous reset mid-frame, then full init again
    pulse_req(f);
    wait_to(f + 50);
    rst = 1'b1;
    #1;
    chk("midrst_E", e, 0);       chk("midrst_RS", rs, 0);   chk("midrst_DATA", d, 0);
    chk("midrst_BUSY", busy, 1); chk("midrst_INIT_DONE", idone, 0);
    @(posedge clk); #1 rst = 1'b0;
    b = wq.size();
    wait_wr(b + 1, 200);
    chk("midrst_first_data", wq[b].d, 8'h38);
    chk("midrst_first_rs", wq[b].rs, 0);
    chk("midrst_first_time", wq[b].t, 70);

    // 4x20 geometry
    for (int r = 0; r < R4; r++)
      for (int c = 0; c < C4; c++) text4[8*(r*C4+c) +: 8] = 8'h41 + 8'(r);
    @(posedge clk); #1 rst4 = 1'b0;
    k = 0;
    while (!idone4 && k < 400) begin @(negedge clk); #1; k++; end
    chk("g4_init_done", idone4, 1);
    b = wq4.size();
    @(posedge clk); #1 req4 = 1'b1; f = ecnt4 + 1;
    @(posedge clk); #1 req4 = 1'b0;
    k = 0;
    while (fq4.size() < 1 && k < 800) begin @(negedge clk); #1; k++; end
    chk("g4_frame_done_seen", fq4.size(), 1);
    chk("g4_frame_len", fq4[0], f + 336);
    chk("g4_write_count", wq4.size() - b, 84);
    for (int r = 0; r < 4; r++) begin
      chk("g4_row_addr", wq4[b+21*r].d, raddr[r]);
      chk("g4_row_addr_rs", wq4[b+21*r].rs, 0);
    end
    chk("g4_row0_char", wq4[b+1].d, 8'h41);
    chk("g4_row3_first", wq4[b+64].d, 8'h44);
    chk("g4_row3_last", wq4[b+83].d, 8'h44);

    chk("bus_protocol", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
